// File: rtl/rom_port_responder.sv
// ============================================================================
// Module      : rom_port_responder
// Description : Responder side of the toggle req/ack port handshake; performs
//               one wait-stated memory access per request toggle, then acks.
//               Optional macro RPR_REQ_SYNC_EN adds a 2-flop port_req sync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_port_responder #(
    parameter int AW      = 23,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            port_req,
    output logic            port_ack,
    input  logic [AW-1:0]   port_a,
    input  logic [DW/8-1:0] port_ds,
    input  logic            port_we,
    input  logic [DW-1:0]   port_d,
    output logic [DW-1:0]   port_q,
    output logic            busy,
    output logic            err,
    input  logic            err_clr,
    output logic            mem_cs,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_rdy
);

    localparam int         c_bw     = DW / 8;
    localparam int         c_cw     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit         c_tmo_en = (TIMEOUT != 0);
    localparam logic [c_cw-1:0] c_tmo_last = c_cw'(TIMEOUT - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_nullop = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_req_seen;
    logic [c_cw-1:0] r_cnt;
    logic            r_we;
    logic [c_bw-1:0] r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            w_req;
    logic            w_start;
    logic            w_tmo;
    logic            w_acc_end;
    logic            w_done;
    logic [DW-1:0]   w_rd_merge;

`ifdef RPR_REQ_SYNC_EN
    // Two-flop synchronizer for an initiator in a foreign clock domain.
    logic [1:0] r_req_sync;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_req_sync <= 2'b00;
        end else begin
            r_req_sync <= {r_req_sync[0], port_req};
        end
    end

    assign w_req = r_req_sync[1];
`else
    assign w_req = port_req;
`endif

    assign w_start   = (r_state == c_st_idle) && (w_req != r_req_seen);
    assign w_tmo     = c_tmo_en && !mem_rdy && (r_cnt == c_tmo_last);
    assign w_acc_end = (r_state == c_st_access) && (mem_rdy || w_tmo);
    assign w_done    = w_acc_end || (r_state == c_st_nullop);

    // Only strobed bytes take new read data; the rest keep the previous value.
    genvar g;
    generate
        for (g = 0; g < c_bw; g++) begin : g_byte_merge
            assign w_rd_merge[g*8 +: 8] = r_be[g] ? mem_rdata[g*8 +: 8]
                                                  : port_q[g*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_start) begin
                    w_state_nxt = (port_ds == '0) ? c_st_nullop : c_st_access;
                end
            end
            c_st_access: begin
                if (mem_rdy || w_tmo) begin
                    w_state_nxt = c_st_idle;
                end
            end
            c_st_nullop: w_state_nxt = c_st_idle;
            default:     w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        busy   = (r_state != c_st_idle);
        mem_cs = (r_state == c_st_access);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_req_seen <= 1'b0;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_be       <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            port_ack   <= 1'b0;
            port_q     <= '0;
            err        <= 1'b0;
        end else begin
            if (w_start) begin
                r_req_seen <= w_req;
                r_we       <= port_we;
                r_be       <= port_ds;
                r_addr     <= port_a;
                r_wdata    <= port_d;
                r_cnt      <= '0;
            end else if ((r_state == c_st_access) && !w_acc_end) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if ((r_state == c_st_access) && mem_rdy && !r_we) begin
                port_q <= w_rd_merge;
            end

            if (w_done) begin
                port_ack <= r_req_seen;
            end

            // A timeout on the same edge as err_clr leaves the flag set.
            if ((r_state == c_st_access) && w_tmo) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

    assign mem_we    = r_we;
    assign mem_be    = r_be;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_rom_port_responder.sv
// ============================================================================
// Module      : tb_rom_port_responder
// Description : Self-checking bench for rom_port_responder (TIMEOUT=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_port_responder;

`ifdef RPR_REQ_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        port_req;
    logic        port_ack;
    logic [22:0] port_a;
    logic [1:0]  port_ds;
    logic        port_we;
    logic [15:0] port_d;
    logic [15:0] port_q;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic        mem_cs;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [22:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rdy;

    rom_port_responder #(.AW(23), .DW(16), .TIMEOUT(8)) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .port_req  (port_req),
        .port_ack  (port_ack),
        .port_a    (port_a),
        .port_ds   (port_ds),
        .port_we   (port_we),
        .port_d    (port_d),
        .port_q    (port_q),
        .busy      (busy),
        .err       (err),
        .err_clr   (err_clr),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
    );

    always #5 clk_sys = ~clk_sys;

    int total = 0;
    int bad   = 0;
    bit req   = 1'b0;
    logic [15:0] q_model = 16'h0000;

    typedef struct {
        logic [1:0]  ds;
        bit          we;
        logic [22:0] a;
        logic [15:0] d;
        int          waits;
        logic [15:0] rd;
        int          exp_cs;
        int          exp_ack;
        logic [15:0] exp_q;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // One request from toggle to ack; the memory side answers after 'waits'
    // extra cycles of mem_cs. Edges are counted from the request toggle.
    task automatic do_access(input logic [1:0] ds, input bit we, input logic [22:0] a,
                             input logic [15:0] d, input int waits, input logic [15:0] rd,
                             input bit hold_clr,
                             output int cs_cycles, output int cs_edge, output int ack_edge);
        port_ds   = ds;
        port_we   = we;
        port_a    = a;
        port_d    = d;
        mem_rdata = rd;
        mem_rdy   = 1'b0;
        err_clr   = hold_clr;
        req       = ~req;
        port_req  = req;
        cs_cycles = 0;
        cs_edge   = 0;
        ack_edge  = 0;
        for (int e = 1; e <= 40 && ack_edge == 0; e++) begin
            tick();
            if (mem_cs) begin
                cs_cycles++;
                if (cs_edge == 0) begin
                    cs_edge = e;
                    chk("mem_addr", mem_addr, a);
                    chk("mem_be", mem_be, ds);
                    chk("mem_we", mem_we, we);
                    chk("mem_wdata", mem_wdata, d);
                end
                chk("busy_in_access", busy, 1'b1);
                mem_rdy = (cs_cycles >= waits + 1);
            end else begin
                mem_rdy = 1'b0;
            end
            if (port_ack == req) ack_edge = e;
        end
        if (ack_edge == 0) chk("ack_never_seen", port_ack, req);
        chk("busy_after_ack", busy, 1'b0);
        mem_rdy = 1'b0;
        err_clr = 1'b0;
    endtask

    int cs_n, cs_e, ack_e;

    initial begin
        reset_n   = 1'b0;
        port_req  = 1'b0;
        port_a    = '0;
        port_ds   = '0;
        port_we   = 1'b0;
        port_d    = '0;
        err_clr   = 1'b0;
        mem_rdata = '0;
        mem_rdy   = 1'b0;

        tbl[0] = '{2'b11, 1'b1, 23'h00010, 16'hA55A, 0, 16'h0000, 1, 2+SL, 16'h0000};
        tbl[1] = '{2'b11, 1'b0, 23'h00020, 16'h0000, 0, 16'hFFFF, 1, 2+SL, 16'hFFFF};
        tbl[2] = '{2'b01, 1'b0, 23'h00021, 16'h0000, 3, 16'h1234, 4, 5+SL, 16'hFF34};
        tbl[3] = '{2'b10, 1'b0, 23'h7FFFFF, 16'h0000, 1, 16'hABCD, 2, 3+SL, 16'hAB34};
        tbl[4] = '{2'b00, 1'b0, 23'h00030, 16'h0000, 0, 16'h9999, 0, 2+SL, 16'hAB34};
        tbl[5] = '{2'b01, 1'b1, 23'h00040, 16'h5555, 2, 16'h7777, 3, 4+SL, 16'hAB34};

        repeat (3) tick();
        chk("rst_port_ack", port_ack, 1'b0);
        chk("rst_port_q", port_q, 16'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_mem_cs", mem_cs, 1'b0);
        chk("rst_mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 32'h0);
        #2 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_access(tbl[i].ds, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].waits, tbl[i].rd,
                      1'b0, cs_n, cs_e, ack_e);
            chk($sformatf("tbl%0d_cs_cycles", i), cs_n, tbl[i].exp_cs);
            chk($sformatf("tbl%0d_ack_edge", i), ack_e, tbl[i].exp_ack);
            chk($sformatf("tbl%0d_port_q", i), port_q, tbl[i].exp_q);
            if (tbl[i].exp_cs != 0) chk($sformatf("tbl%0d_cs_edge", i), cs_e, 1 + SL);
        end
        q_model = 16'hAB34;

        // Timeout, err clear, then timeout coinciding with err_clr
        do_access(2'b11, 1'b0, 23'h00100, 16'h0, 1000, 16'h1111, 1'b0, cs_n, cs_e, ack_e);
        chk("tmo_cs_cycles", cs_n, 8);
        chk("tmo_ack_edge", ack_e, 9 + SL);
        chk("tmo_err", err, 1'b1);
        chk("tmo_q_kept", port_q, q_model);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_cleared", err, 1'b0);
        do_access(2'b11, 1'b0, 23'h00101, 16'h0, 1000, 16'h2222, 1'b1, cs_n, cs_e, ack_e);
        chk("tmo2_cs_cycles", cs_n, 8);
        chk("tmo2_err_wins", err, 1'b1);

        // Back-to-back writes, each toggled the moment the previous ack lands
        for (int i = 0; i < 16; i++) begin
            do_access(2'b11, 1'b1, 23'(i), 16'(i * 16'h0101), 0, 16'h0, 1'b0, cs_n, cs_e, ack_e);
            chk($sformatf("b2b%0d_cs_edge", i), cs_e, 1 + SL);
            chk($sformatf("b2b%0d_cs_cycles", i), cs_n, 1);
        end

        // Reset during the 17th access, released with port_req high
        port_a    = 23'd16;
        port_ds   = 2'b11;
        port_we   = 1'b0;
        mem_rdata = 16'hBEEF;
        mem_rdy   = 1'b0;
        req       = ~req;
        port_req  = req;
        repeat (2 + SL) tick();
        chk("mid_cs", mem_cs, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ack", port_ack, 1'b0);
        chk("midrst_busy_err_cs", {busy, err, mem_cs}, 3'b000);
        chk("midrst_q", port_q, 16'h0);
        chk("midrst_mem_bus", {mem_we, mem_be, mem_addr, mem_wdata}, 32'h0);
        req      = 1'b1;
        port_req = 1'b1;
        #1 reset_n = 1'b1;
        cs_e = 0;
        for (int e = 1; e <= 10 && cs_e == 0; e++) begin
            tick();
            if (mem_cs) cs_e = e;
        end
        chk("post_rst_cs_edge", cs_e, 1 + SL);
        mem_rdy = 1'b1;
        tick();
        mem_rdy = 1'b0;
        chk("post_rst_ack", port_ack, 1'b1);
        chk("post_rst_q", port_q, 16'hBEEF);
        q_model = 16'hBEEF;

        // Randomized traffic against the byte-lane model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  r_ds;
            bit          r_we;
            logic [22:0] r_a;
            logic [15:0] r_d, r_rd, mask;
            int          r_w;
            r_ds = 2'($urandom_range(0, 3));
            r_we = 1'($urandom_range(0, 1));
            r_a  = 23'($urandom);
            r_d  = 16'($urandom);
            r_rd = 16'($urandom);
            r_w  = $urandom_range(0, 4);
            do_access(r_ds, r_we, r_a, r_d, r_w, r_rd, 1'b0, cs_n, cs_e, ack_e);
            mask = {{8{r_ds[1]}}, {8{r_ds[0]}}};
            if (!r_we) q_model = (q_model & ~mask) | (r_rd & mask);
            chk($sformatf("rnd%0d_cs_cycles", i), cs_n, (r_ds == 2'b00) ? 0 : r_w + 1);
            chk($sformatf("rnd%0d_ack_edge", i), ack_e, (r_ds == 2'b00) ? 2 + SL : 2 + SL + r_w);
            chk($sformatf("rnd%0d_port_q", i), port_q, q_model);
            chk($sformatf("rnd%0d_err", i), err, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule

`default_nettype wire

// File: doc/rom_port_responder.md
Name: rom_port_responder

Overview:
- Responder end of the toggle req/ack port handshake used by the ROM download controller and the hiscore logic to reach SDRAM ports.
- An initiator toggles `port_req` with address, byte strobes, write-enable and data held stable.
- This block performs one access on a generic wait-stated memory bus, captures read data, then toggles `port_ack` to mirror `port_req`.
- Sits between initiators in `emu` and a memory controller or BRAM bank.

Parameters:
- AW, 23, word address width (16-bit words)
- DW, 16, data width; byte strobes are DW/8 wide
- TIMEOUT, 255, max mem wait cycles before abort; 0 disables the timeout

Ports:
- clk_sys  in  1  sole clock
- reset_n  in  1  asynchronous active-low reset
- port_req  in  1  request toggle from initiator
- port_ack  out  1  acknowledge toggle; equals port_req when idle/complete
- port_a  in  AW  word address
- port_ds  in  DW/8  byte strobes ({hi,lo})
- port_we  in  1  1=write, 0=read
- port_d  in  DW  write data
- port_q  out  DW  read data, valid when port_ack==port_req
- busy  out  1  access in flight
- err  out  1  sticky timeout flag
- err_clr  in  1  clears err
- mem_cs  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_be  out  DW/8  memory byte enables
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_rdy  in  1  access complete, sampled only while mem_cs=1

Behaviour:
- Reset (async, reset_n=0) clears all state:
  - outputs: port_ack=0, port_q=0, busy=0, err=0, mem_cs=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0
  - internal: req_seen=0, wait counter=0, FSM=IDLE
- Reset mid-access:
  - abandons the access with no ack toggle.
  - If port_req=1 at reset release, a request is detected on the first edge.
- FSM states: IDLE, ACCESS, NULLOP.
- IDLE: on an edge where port_req != req_seen:
  - latch port_a/ds/we/d and set req_seen<=port_req; busy<=1.
  - If port_ds==0: go to NULLOP (no memory access).
  - Else: go to ACCESS, driving mem_cs=1, mem_we=port_we, mem_be=port_ds, mem_addr=port_a, mem_wdata=port_d.
- ACCESS: mem_* outputs held stable, wait counter increments each cycle.
  - On an edge with mem_rdy=1:
    - reads: port_q<=mem_rdata, and only bytes whose strobe is set update (others keep their old value).
    - writes: port_q unchanged.
    - mem_cs<=0, busy<=0, port_ack<=req_seen, go to IDLE.
  - If TIMEOUT!=0 and counter reaches TIMEOUT with no mem_rdy:
    - mem_cs<=0, err<=1, port_ack<=req_seen (no initiator hang), port_q unchanged, go to IDLE.
- NULLOP: one cycle, then port_ack<=req_seen, busy<=0, go to IDLE.
- Latency, zero-wait memory (mem_rdy tied 1), counting edges after port_req toggles:
  - edge 1: mem_cs high.
  - edge 2: port_ack toggles.
  - Each extra mem wait cycle adds 1 cycle.
- Back-to-back: a new toggle already present in IDLE is accepted on the very next edge; no dead cycle is required.
- Toggles while busy:
  - not sampled until IDLE.
  - Two toggles during one access return parity to req_seen, so the second request is lost. This is initiator protocol violation, not detected.
- err_clr and a timeout on the same edge: the timeout wins, err=1.
- Counter width: ceil(log2(TIMEOUT+1)); it resets on each new access.

Optional Feature:
- Macro RPR_REQ_SYNC_EN.
- When defined:
  - port_req passes through a 2-flop synchronizer (reset to 0) before comparison, so an initiator in another clock domain is supported.
  - Latency grows by 2 cycles.
  - Address/data are latched when the synchronized toggle is seen and must be held by the initiator until ack.
- When undefined: port_req is compared directly, with the latency above.

Test Plan:
- Write, zero-wait: reset, port_a=0x00010, ds=2'b11, we=1, d=0xA55A, toggle req 0→1 → mem_cs=1 for 1 cycle with be=11, addr=0x00010, wdata=0xA55A; port_ack=1 two edges after the toggle; busy high exactly one cycle.
- Read with 3 wait cycles: mem_rdata=0x1234, ds=2'b01, prior port_q=0xFFFF → mem_cs high 4 cycles; port_q=0xFF34; ack toggles on the mem_rdy edge.
- Null op: ds=2'b00, toggle req → no mem_cs pulse; port_ack toggles after 2 edges.
- Timeout: TIMEOUT=8, mem_rdy held 0 → mem_cs drops after 8 cycles; err=1; ack toggles. err_clr pulse → err=0. Simultaneous err_clr with a second timeout → err stays 1.
- Back-to-back and reset: 16 consecutive writes toggling req immediately on each ack → 16 mem_cs pulses with addresses in order. Assert reset_n=0 during the 17th access (mem_rdy low) → all outputs 0 immediately. Release with port_req=1 → a new access starts on the first edge.
- With RPR_REQ_SYNC_EN: repeat the first write → mem_cs rises 3 edges after the toggle and ack toggles at edge 4.
